// File: rtl/spi_master_nbit_pkg.sv
// Shared definitions for the SPI master: FSM encoding and chip-select index sizing.
package spi_master_nbit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_TRAIL = 2'd3
  } spi_state_e;

  // Index width for a bank of n chip selects; never narrower than one bit.
  function automatic int cs_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_master_nbit_edge_gen.sv
// Half-period timer: emits a one-cycle tick every divider+1 enabled clk cycles.
module spi_master_nbit_edge_gen #(
  parameter int DIV_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  // One extra bit so the compare against divider can never alias on wrap.
  logic [DIV_W:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == {1'b0, div_i});

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || !en_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master_nbit.sv
// Single-word SPI master: all CPOL/CPHA modes, MSB/LSB-first, multi-CS with hold,
// and a CS-less clocking mode with MOSI forced high for SD-card wake-up.
module spi_master_nbit
  import spi_master_nbit_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DIV_W  = 5,
  parameter  int NUM_CS = 2,
  localparam int CS_W   = cs_width(NUM_CS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  divider,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cs_hold,
  input  logic              no_cs,
  input  logic              cs_release,
  input  logic [DATA_W-1:0] data_tx,
  input  logic              txn_start,
  output logic              txn_ready,
  output logic              rx_valid,
  output logic [DATA_W-1:0] data_rx,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n
);

  localparam int EC_W = $clog2(2 * DATA_W);
  localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2 * DATA_W - 1);

  spi_state_e        state_q;
  logic [DIV_W-1:0]  div_q;
  logic [DATA_W-1:0] tx_q, rx_q, data_rx_q;
  logic [EC_W-1:0]   edge_q;
  logic [NUM_CS-1:0] cs_n_q;
  logic              cpha_q, lsb_q, hold_q, nocs_q;
  logic              sclk_q, mosi_q, rx_valid_q;

  logic              accept, tick;
  logic [NUM_CS-1:0] cs_sel_n;
  logic              tx_first_bit, tx_bit;
  logic [DATA_W-1:0] data_tx_sh, tx_sh, rx_in;

  assign accept = (state_q == ST_IDLE) && txn_start;

  spi_master_nbit_edge_gen #(.DIV_W(DIV_W)) u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (accept),
    .en_i   (state_q != ST_IDLE),
    .div_i  (div_q),
    .tick_o (tick)
  );

  // An out-of-range index matches no lane, leaving every CS deasserted.
  always_comb begin
    cs_sel_n = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (cs_sel == CS_W'(i)) cs_sel_n[i] = 1'b0;
  end

  assign tx_first_bit = lsb_first ? data_tx[0] : data_tx[DATA_W-1];
  assign data_tx_sh   = lsb_first ? (data_tx >> 1) : (data_tx << 1);
  assign tx_bit       = lsb_q ? tx_q[0] : tx_q[DATA_W-1];
  assign tx_sh        = lsb_q ? (tx_q >> 1) : (tx_q << 1);
  assign rx_in        = lsb_q ? {spi_miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], spi_miso};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      data_rx_q  <= '0;
      edge_q     <= '0;
      cs_n_q     <= '1;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      hold_q     <= 1'b0;
      nocs_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          sclk_q <= cpol;
          if (txn_start) begin
            div_q  <= divider;
            cpha_q <= cpha;
            lsb_q  <= lsb_first;
            hold_q <= cs_hold;
            nocs_q <= no_cs;
            edge_q <= '0;
            cs_n_q <= no_cs ? '1 : cs_sel_n;
            // cpha=0 must present the first bit before the first leading edge.
            if (cpha) begin
              tx_q <= data_tx;
              if (no_cs) mosi_q <= 1'b1;
            end else begin
              tx_q   <= data_tx_sh;
              mosi_q <= no_cs | tx_first_bit;
            end
            state_q <= ST_LEAD;
          end else if (cs_release) begin
            cs_n_q <= '1;
          end
        end
        ST_LEAD: if (tick) state_q <= ST_SHIFT;
        ST_SHIFT: if (tick) begin
          sclk_q <= ~sclk_q;
          edge_q <= edge_q + 1'b1;
          // edge_q[0]==0 is a leading edge; sample on leading iff cpha=0.
          if (edge_q[0] == cpha_q) begin
            rx_q <= rx_in;
          end else if (edge_q != LAST_EDGE) begin
            mosi_q <= nocs_q | tx_bit;
            tx_q   <= tx_sh;
          end
          if (edge_q == LAST_EDGE) state_q <= ST_TRAIL;
        end
        ST_TRAIL: if (tick) begin
          data_rx_q  <= rx_q;
          rx_valid_q <= 1'b1;
          if (!hold_q) cs_n_q <= '1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign txn_ready = (state_q == ST_IDLE);
  assign rx_valid  = rx_valid_q;
  assign data_rx   = data_rx_q;
  assign spi_clk   = sclk_q;
  assign spi_mosi  = mosi_q;
  assign spi_cs_n  = cs_n_q;

endmodule
